// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state type for the bit-serial subtractor.
package serial_sub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/full_sub.sv
// full_sub: combinational 1-bit full subtractor cell.
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor, one bit per clock LSB first, start/done handshake.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CNT_W = $clog2(WIDTH);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d, borrow_q, borrow_d, d, bout, last;
    full_sub u_fs (.x(a_q[0]), .y(b_q[0]), .bin(br_q), .d(d), .bout(bout));
    assign last   = cnt_q == CNT_W'(WIDTH - 1);
    assign busy   = state_q == RUN;
    assign done   = state_q == DONE;
    assign diff   = diff_q;
    assign borrow = borrow_q;
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sh_d     = sh_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                a_d     = a;
                b_d     = b;
                sh_d    = '0;
                br_d    = 1'b0;
                cnt_d   = '0;
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                // each difference bit enters at the MSB so the first (LSB) ends up in bit 0
                sh_d  = (sh_q >> 1) | {d, {(WIDTH-1){1'b0}}};
                br_d  = bout;
                cnt_d = last ? cnt_q : cnt_q + CNT_W'(1);
                if (last) begin
                    state_d  = DONE;
                    diff_d   = sh_d;
                    borrow_d = bout;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: randomized and directed checks of serial_sub at WIDTH=4 and WIDTH=8 against an arithmetic model.
module tb_serial_sub;
    logic       clk, reset;
    logic       start4, busy4, done4, borrow4;
    logic [3:0] a4, b4, diff4;
    logic       start8, busy8, done8, borrow8;
    logic [7:0] a8, b8, diff8;
    int         n_cmp = 0;
    int         n_bad = 0;

    serial_sub #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
    );
    serial_sub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int get_busy(input int w);
        return w == 4 ? int'(busy4) : int'(busy8);
    endfunction
    function automatic int get_done(input int w);
        return w == 4 ? int'(done4) : int'(done8);
    endfunction
    function automatic int get_diff(input int w);
        return w == 4 ? int'(diff4) : int'(diff8);
    endfunction
    function automatic int get_borrow(input int w);
        return w == 4 ? int'(borrow4) : int'(borrow8);
    endfunction

    task automatic drive(input int w, input logic s, input int av, input int bv);
        if (w == 4) begin
            start4 = s;
            a4 = 4'(av);
            b4 = 4'(bv);
        end else begin
            start8 = s;
            a8 = 8'(av);
            b8 = 8'(bv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation from IDLE; the model is plain integer subtraction.
    task automatic do_op(input int w, input int av, input int bv);
        int r, n, bc;
        r = av - bv;
        drive(w, 1'b1, av, bv);
        tick();
        drive(w, 1'b0, $urandom_range(0, (1 << w) - 1), $urandom_range(0, (1 << w) - 1));
        n = 0;
        bc = 0;
        while (get_done(w) == 0 && n < 40) begin
            bc += get_busy(w);
            tick();
            n++;
        end
        chk("latency", n, w);
        chk("busy_cycles", bc, w);
        chk("busy_at_done", get_busy(w), 0);
        chk("diff", get_diff(w), r & ((1 << w) - 1));
        chk("borrow", get_borrow(w), int'(r < 0));
        tick();
        chk("done_pulse", get_done(w), 0);
        chk("diff_hold", get_diff(w), r & ((1 << w) - 1));
    endtask

    initial begin
        reset = 1'b1;
        drive(4, 1'b0, 0, 0);
        drive(8, 1'b0, 0, 0);
        tick();
        tick();
        chk("rst_busy4", int'(busy4), 0);
        chk("rst_done4", int'(done4), 0);
        chk("rst_diff4", int'(diff4), 0);
        chk("rst_borrow4", int'(borrow4), 0);
        chk("rst_busy8", int'(busy8), 0);
        chk("rst_diff8", int'(diff8), 0);
        reset = 1'b0;
        tick();
        do_op(4, 9, 3);
        do_op(4, 3, 9);
        do_op(4, 5, 5);
        do_op(4, 0, 15);
        // start held for 8 edges with operands changing after acceptance
        drive(4, 1'b1, 12, 4);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) drive(4, 1'b1, 1, 1);
            if (i == 8) drive(4, 1'b0, 1, 1);
            chk("held_done", int'(done4), int'(i == 5 || i == 11));
            chk("held_busy", int'(busy4), int'((i >= 1 && i <= 4) || (i >= 7 && i <= 10)));
            if (i == 5) begin
                chk("held_diff", int'(diff4), 8);
                chk("held_borrow", int'(borrow4), 0);
            end
            if (i == 11) chk("held_diff2", int'(diff4), 0);
        end
        do_op(4, 3, 9);
        // reset in the second RUN cycle abandons the operation
        drive(4, 1'b1, 7, 2);
        tick();
        drive(4, 1'b0, 7, 2);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", int'(busy4), 0);
        chk("mid_rst_done", int'(done4), 0);
        chk("mid_rst_diff", int'(diff4), 0);
        chk("mid_rst_borrow", int'(borrow4), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("no_done_after_rst", int'(done4), 0);
        end
        do_op(4, 7, 2);
        // reset and start on the same edge: reset wins
        reset = 1'b1;
        drive(4, 1'b1, 6, 1);
        tick();
        reset = 1'b0;
        drive(4, 1'b0, 6, 1);
        chk("rst_start_busy", int'(busy4), 0);
        tick();
        chk("rst_start_busy2", int'(busy4), 0);
        do_op(8, 255, 0);
        do_op(8, 0, 1);
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            do_op(4, $urandom_range(0, 15), $urandom_range(0, 15));
        end
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            do_op(8, $urandom_range(0, 255), $urandom_range(0, 255));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
